uart_rcvr: RTL and testbench

- Receive side of the team's 7-bit UART link. Deserialises frames: start (0), 7 data bits LSB-first, 1 parity bit, stop (1).
- Samples the asynchronous `rx` line using a 16x oversampling tick from the shared baud generator.
- Presents the received byte, a one-cycle valid strobe, and parity/framing error flags to the host logic.
- `p_sel` selects parity polarity, matching the transmitter: 1 = even (parity bit = ^data), 0 = odd (parity bit = ~^data).

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_rx_sync.sv | 20 ++
 rtl/uart_rcvr.sv | 170 +++++++++++++++++
 tb/tb_uart_rcvr.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default sizes and the parity helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

  localparam int unsigned UART_DATA_BITS  = 7;
  localparam int unsigned UART_OVERSAMPLE = 16;
  localparam int unsigned UART_PAR_W      = 16;

  // Zero padding leaves the XOR unchanged, so any data width up to UART_PAR_W works.
  function automatic logic uart_parity(input logic [UART_PAR_W-1:0] data, input logic p_sel);
    return p_sel ? ^data : ~^data;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Multi-flop synchroniser for the asynchronous rx line; resets to the idle (high) level.
module uart_rx_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (reset) chain <= '1;
    else       chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/uart_rcvr.sv
// 7-bit UART receiver (start, data LSB-first, parity, stop) with 16x oversampling.
// Define UART_RX_MAJORITY_EN to decide each bit by a 2-of-3 vote around mid-bit.
module uart_rcvr
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE  = UART_OVERSAMPLE,
  parameter int unsigned DATA_BITS   = UART_DATA_BITS,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  input  logic                 p_sel,
  input  logic                 os_tick,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int unsigned CW = $clog2(OVERSAMPLE);
  localparam int unsigned BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] MID_START = CW'(OVERSAMPLE/2 - 1);
  localparam logic [CW-1:0] MID_BIT   = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  uart_state_t          state, state_nx;
  logic [CW-1:0]        os_cnt, os_cnt_nx;
  logic [BW-1:0]        bit_cnt, bit_cnt_nx;
  logic [DATA_BITS-1:0] shift_reg, shift_nx;
  logic                 par_bit, par_bit_nx;
  logic                 par_exp, par_exp_nx;
  logic                 armed, armed_nx;
  logic [DATA_BITS-1:0] data_out_nx;
  logic                 data_valid_nx, parity_err_nx, frame_err_nx;

  logic          rx_s;
  logic [CW-1:0] mid_cnt, hit_cnt;
  logic          samp_hit, samp_val;

  uart_rx_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

  assign mid_cnt = (state == START) ? MID_START : MID_BIT;

`ifdef UART_RX_MAJORITY_EN
  logic [CW-1:0] pre_cnt;
  logic [1:0]    vote;

  assign pre_cnt  = mid_cnt - CW'(1);
  assign hit_cnt  = mid_cnt + CW'(1);
  assign samp_val = (vote[0] & vote[1]) | (vote[0] & rx_s) | (vote[1] & rx_s);

  // Votes taken at mid-1 and mid; the tick at mid+1 supplies the third and decides.
  always_ff @(posedge clk) begin
    if (reset) begin
      vote <= '0;
    end else if (os_tick && (state != IDLE)) begin
      if (os_cnt == pre_cnt)      vote[0] <= rx_s;
      else if (os_cnt == mid_cnt) vote[1] <= rx_s;
    end
  end
`else
  assign hit_cnt  = mid_cnt;
  assign samp_val = rx_s;
`endif

  assign samp_hit = os_tick && (state != IDLE) && (os_cnt == hit_cnt);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      os_cnt     <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      par_bit    <= 1'b0;
      par_exp    <= 1'b0;
      armed      <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nx;
      os_cnt     <= os_cnt_nx;
      bit_cnt    <= bit_cnt_nx;
      shift_reg  <= shift_nx;
      par_bit    <= par_bit_nx;
      par_exp    <= par_exp_nx;
      armed      <= armed_nx;
      data_out   <= data_out_nx;
      data_valid <= data_valid_nx;
      parity_err <= parity_err_nx;
      frame_err  <= frame_err_nx;
      busy       <= (state_nx != IDLE);
    end
  end

  // os_cnt free-runs mod OVERSAMPLE outside IDLE, so bit periods stay exactly OVERSAMPLE ticks.
  always_comb begin
    state_nx      = state;
    os_cnt_nx     = os_cnt;
    bit_cnt_nx    = bit_cnt;
    shift_nx      = shift_reg;
    par_bit_nx    = par_bit;
    par_exp_nx    = par_exp;
    armed_nx      = armed;
    data_out_nx   = data_out;
    data_valid_nx = 1'b0;
    parity_err_nx = parity_err;
    frame_err_nx  = frame_err;

    if (os_tick && (state != IDLE)) os_cnt_nx = os_cnt + CW'(1);

    case (state)
      IDLE: begin
        if (rx_s) begin
          armed_nx = 1'b1;
        end else if (armed) begin
          os_cnt_nx = '0;
          state_nx  = START;
        end
      end
      START: begin
        if (samp_hit) begin
          if (samp_val) begin
            state_nx = IDLE;
          end else begin
            // Re-phase so the first data decision lands one bit period later.
            os_cnt_nx  = hit_cnt - MID_START;
            bit_cnt_nx = '0;
            state_nx   = DATA;
          end
        end
      end
      DATA: begin
        if (samp_hit) begin
          shift_nx[bit_cnt] = samp_val;
          if (bit_cnt == BIT_LAST) state_nx = PARITY;
          else                     bit_cnt_nx = bit_cnt + BW'(1);
        end
      end
      PARITY: begin
        if (samp_hit) begin
          par_bit_nx = samp_val;
          par_exp_nx = uart_parity(UART_PAR_W'(shift_reg), p_sel);
          state_nx   = STOP;
        end
      end
      STOP: begin
        if (samp_hit) begin
          data_out_nx   = shift_reg;
          parity_err_nx = (par_bit != par_exp);
          frame_err_nx  = ~samp_val;
          data_valid_nx = 1'b1;
          armed_nx      = samp_val;
          state_nx      = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_rcvr.sv
// Scoreboard bench for uart_rcvr: frames are serialised at bit level, expected results queued, monitor checks each data_valid.
module tb_uart_rcvr;

  logic       clk;
  logic       reset;
  logic       rx;
  logic       p_sel;
  logic       os_tick;
  logic [6:0] data_out;
  logic       data_valid;
  logic       parity_err;
  logic       frame_err;
  logic       busy;

  typedef struct packed {
    logic [6:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;

  uart_rcvr dut (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .p_sel      (p_sel),
    .os_tick    (os_tick),
    .data_out   (data_out),
    .data_valid (data_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // os_tick: one clk high every 4 clks
  initial begin
    os_tick = 1'b0;
    forever begin
      repeat (3) @(negedge clk);
      os_tick = 1'b1;
      @(negedge clk);
      os_tick = 1'b0;
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: time limit reached, tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference parity bit: even -> total ones even, odd -> total ones odd.
  function automatic logic model_parity(input logic [6:0] d, input logic even);
    int ones;
    ones = $countones(d);
    if (even) return (ones % 2) == 1;
    return (ones % 2) == 0;
  endfunction

  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      while (!os_tick) @(posedge clk);
    end
  endtask

  task automatic send_level(input logic v, input int n);
    @(negedge clk);
    rx = v;
    wait_ticks(n);
  endtask

  // glitch inverts the line for one tick at the mid-point of every data bit.
  task automatic send_frame(input logic [6:0] d, input logic ps, input logic bad_par,
                            input logic stop_b, input logic glitch);
    logic [6:0] rcv;
    logic       pb;
    exp_t       e;
    pb = model_parity(d, ps) ^ bad_par;
`ifdef UART_RX_MAJORITY_EN
    rcv = d;
`else
    rcv = glitch ? ~d : d;
`endif
    e.data = rcv;
    e.perr = (pb != model_parity(rcv, ps));
    e.ferr = ~stop_b;
    exp_q.push_back(e);
    p_sel = ps;
    send_level(1'b0, 16);
    for (int i = 0; i < 7; i++) begin
      if (glitch) begin
        send_level(d[i], 7);
        send_level(~d[i], 1);
        send_level(d[i], 8);
      end else begin
        send_level(d[i], 16);
      end
    end
    send_level(pb, 16);
    send_level(stop_b, 16);
    check("frame_done_pending", 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: every data_valid cycle must consume exactly one expected frame.
  always @(negedge clk) begin
    if (!reset && data_valid) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_valid: got data_out=0x%0h, expected no data_valid (t=%0t)", data_out, $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("data_out", 32'(data_out), 32'(mon_e.data));
        check("parity_err", 32'(parity_err), 32'(mon_e.perr));
        check("frame_err", 32'(frame_err), 32'(mon_e.ferr));
      end
    end
  end

  initial begin
    logic [6:0] d;
    logic       ps, bad, st;
    int         gap;

    rx    = 1'b1;
    p_sel = 1'b1;
    reset = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_data_out", 32'(data_out), 32'd0);
    check("rst_data_valid", 32'(data_valid), 32'd0);
    check("rst_parity_err", 32'(parity_err), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    wait_ticks(4);

    // Directed frames
    send_frame(7'h55, 1'b1, 1'b0, 1'b1, 1'b0);
    send_frame(7'h2A, 1'b0, 1'b1, 1'b1, 1'b0);

    // Framing error followed by a held-low line: no retrigger until the line goes high
    send_frame(7'h7F, 1'b1, 1'b0, 1'b0, 1'b0);
    send_level(1'b0, 48);
    check("held_low_busy", 32'(busy), 32'd0);
    send_level(1'b1, 16);
    send_frame(7'h01, 1'b1, 1'b0, 1'b1, 1'b0);

    // Short low glitch: false start
    send_level(1'b0, 3);
    @(negedge clk);
    check("glitch_busy_high", 32'(busy), 32'd1);
    send_level(1'b1, 32);
    check("glitch_busy_low", 32'(busy), 32'd0);

    // Reset during bit 3 of 7'h33
    p_sel = 1'b1;
    d = 7'h33;
    send_level(1'b0, 16);
    for (int i = 0; i < 3; i++) send_level(d[i], 16);
    send_level(d[3], 8);
    @(negedge clk);
    reset = 1'b1;
    rx    = 1'b1;
    @(negedge clk);
    check("midrst_data_out", 32'(data_out), 32'd0);
    check("midrst_data_valid", 32'(data_valid), 32'd0);
    check("midrst_parity_err", 32'(parity_err), 32'd0);
    check("midrst_frame_err", 32'(frame_err), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    wait_ticks(8);
    send_frame(7'h4C, 1'b0, 1'b0, 1'b1, 1'b0);

    // Mid-bit single-tick glitches on every data bit
    send_frame(7'h55, 1'b1, 1'b0, 1'b1, 1'b1);
    send_level(1'b1, 4);

    // Randomised frames
    for (int k = 0; k < 20; k++) begin
      d   = 7'($urandom_range(0, 127));
      ps  = 1'($urandom_range(0, 1));
      bad = ($urandom_range(0, 3) == 0);
      st  = ($urandom_range(0, 4) != 0);
      gap = st ? int'($urandom_range(0, 6)) : int'($urandom_range(2, 6));
      send_frame(d, ps, bad, st, 1'b0);
      if (gap > 0) send_level(1'b1, gap);
    end

    send_level(1'b1, 32);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    check("final_busy", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
